// File: rtl/slow_division_stage.sv
// slow_division_stage: one registered restoring-division step that retires one quotient bit
module slow_division_stage #(
    parameter int WIDTH = 6,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic             valid_i,
    input  logic             dbz_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o,
    output logic [WIDTH-1:0] div_o,
    output logic [WIDTH-1:0] quot_o,
    output logic             valid_o,
    output logic             dbz_o
);
    logic [WIDTH:0]   trial, diff;
    logic             ge;
    logic [WIDTH-1:0] rem_d, dvd_d, quot_d, rem_q, dvd_q, div_q, quot_q;
    logic             dbz_d, valid_q, dbz_q;

    // Dividend is kept MSB-aligned, so the bit entering this stage is always the top one
    always_comb begin
        trial  = {rem_i, dvd_i[WIDTH-1]};
        diff   = trial - {1'b0, div_i};
        ge     = trial >= {1'b0, div_i};
        rem_d  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d  = {dvd_i[WIDTH-2:0], 1'b0};
        quot_d = {quot_i[WIDTH-2:0], ge};
        dbz_d  = (STAGE == 0) ? (div_i == '0) : dbz_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (en_i) begin
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_i;
            quot_q  <= quot_d;
            valid_q <= valid_i;
            dbz_q   <= dbz_d;
        end
    end

    assign rem_o   = rem_q;
    assign dvd_o   = dvd_q;
    assign div_o   = div_q;
    assign quot_o  = quot_q;
    assign valid_o = valid_q;
    assign dbz_o   = dbz_q;
endmodule

// File: rtl/slow_division.sv
// slow_division: WIDTH-stage pipelined unsigned restoring divider, one result per enabled cycle
module slow_division #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             out_valid
);
    // Index 0 is the pipeline entry; index s+1 is the output of stage s
    logic [WIDTH-1:0] stage_rem  [WIDTH+1];
    logic [WIDTH-1:0] stage_quot [WIDTH+1];
    logic [WIDTH-1:0] stage_div  [WIDTH+1];
    logic [WIDTH-1:0] stage_dvd  [WIDTH+1];
    logic             stage_valid[WIDTH+1];
    logic             stage_dbz  [WIDTH+1];

    assign stage_rem[0]   = '0;
    assign stage_quot[0]  = '0;
    assign stage_div[0]   = divisor;
    assign stage_dvd[0]   = dividend;
    assign stage_valid[0] = in_valid;
    assign stage_dbz[0]   = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        slow_division_stage #(.WIDTH(WIDTH), .STAGE(i)) u_stage (
            .clk    (clk),
            .rst_n  (reset),
            .en_i   (enable),
            .rem_i  (stage_rem[i]),
            .dvd_i  (stage_dvd[i]),
            .div_i  (stage_div[i]),
            .quot_i (stage_quot[i]),
            .valid_i(stage_valid[i]),
            .dbz_i  (stage_dbz[i]),
            .rem_o  (stage_rem[i+1]),
            .dvd_o  (stage_dvd[i+1]),
            .div_o  (stage_div[i+1]),
            .quot_o (stage_quot[i+1]),
            .valid_o(stage_valid[i+1]),
            .dbz_o  (stage_dbz[i+1])
        );
    end

    assign quotient    = stage_quot[WIDTH];
    assign remainder   = stage_rem[WIDTH];
    assign div_by_zero = stage_dbz[WIDTH];
    assign out_valid   = stage_valid[WIDTH];
endmodule

// File: tb/tb_slow_division.sv
// tb_slow_division: table and randomized checks of slow_division against a delay-line result model
module tb_slow_division;
    localparam int W = 6;
    localparam logic [W-1:0] ALL1 = '1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero, out_valid;

    slow_division #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           v;
        logic [W-1:0] q, r;
        bit           z;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        bit           z;
    } vec_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic exp_t model(bit v, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        e.v = v;
        e.z = (b == 0);
        e.q = (b == 0) ? ALL1 : W'(int'(a) / int'(b));
        e.r = (b == 0) ? a : W'(int'(a) % int'(b));
        return e;
    endfunction

    // One clock: drive inputs, take the edge, advance the expected-result delay line, compare
    task automatic cycle(string tag, bit en, bit v, logic [W-1:0] a, logic [W-1:0] b, exp_t e);
        enable = en;
        in_valid = v;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        if (en) begin
            sb.push_back(e);
            if (sb.size() > W) void'(sb.pop_front());
        end
        check({tag, ".valid"}, out_valid, sb[0].v);
        if (sb[0].v) begin
            check({tag, ".q"}, quotient, sb[0].q);
            check({tag, ".r"}, remainder, sb[0].r);
            check({tag, ".dbz"}, div_by_zero, sb[0].z);
        end
    endtask

    task automatic idle(string tag, int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, W'($urandom), W'($urandom), model(1'b0, '0, '0));
    endtask

    task automatic do_reset(string tag, int n);
        exp_t blank;
        blank = '{default: 0};
        reset = 1'b0;
        #1;
        check({tag, ".valid"}, out_valid, 0);
        check({tag, ".q"}, quotient, 0);
        check({tag, ".r"}, remainder, 0);
        check({tag, ".dbz"}, div_by_zero, 0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        repeat (W - 1) sb.push_back(blank);
    endtask

    initial begin
        vec_t tbl[10];
        exp_t e;
        tbl[0] = '{6'd60, 6'd7,  6'd8,  6'd4,  1'b0};
        tbl[1] = '{6'd10, 6'd12, 6'd0,  6'd10, 1'b0};
        tbl[2] = '{6'd63, 6'd1,  6'd63, 6'd0,  1'b0};
        tbl[3] = '{6'd5,  6'd0,  6'd63, 6'd5,  1'b1};
        tbl[4] = '{6'd6,  6'd6,  6'd1,  6'd0,  1'b0};
        tbl[5] = '{6'd0,  6'd5,  6'd0,  6'd0,  1'b0};
        tbl[6] = '{6'd63, 6'd63, 6'd1,  6'd0,  1'b0};
        tbl[7] = '{6'd1,  6'd63, 6'd0,  6'd1,  1'b0};
        tbl[8] = '{6'd0,  6'd0,  6'd63, 6'd0,  1'b1};
        tbl[9] = '{6'd62, 6'd2,  6'd31, 6'd0,  1'b0};

        do_reset("reset", 3);
        idle("post_reset", 3);

        for (int i = 0; i < 10; i++) begin
            e.v = 1'b1;
            e.q = tbl[i].q;
            e.r = tbl[i].r;
            e.z = tbl[i].z;
            cycle($sformatf("tbl%0d", i), 1'b1, 1'b1, tbl[i].a, tbl[i].b, e);
        end
        idle("tbl_drain", W);

        // 40/3 followed by a 4-cycle stall: outputs must hold and latency counts enabled edges only
        cycle("stall_op", 1'b1, 1'b1, 6'd40, 6'd3, '{1'b1, 6'd13, 6'd1, 1'b0});
        cycle("stall_pre", 1'b1, 1'b0, '0, '0, model(1'b0, '0, '0));
        for (int i = 0; i < 4; i++) cycle("stall_hold", 1'b0, 1'b1, 6'd63, 6'd9, model(1'b1, 6'd63, 6'd9));
        idle("stall_post", W);

        for (int i = 0; i < 48; i++) begin
            logic [W-1:0] a, b;
            bit v;
            a = W'($urandom);
            b = W'($urandom_range(0, 63));
            v = (i % 2 == 0);
            cycle("rand", 1'b1, v, a, b, model(v, a, b));
        end
        idle("rand_drain", W);

        // Three operations in flight when reset pulses; none may emerge afterwards
        cycle("flight0", 1'b1, 1'b1, 6'd50, 6'd5, model(1'b1, 6'd50, 6'd5));
        cycle("flight1", 1'b1, 1'b1, 6'd33, 6'd4, model(1'b1, 6'd33, 6'd4));
        cycle("flight2", 1'b1, 1'b1, 6'd17, 6'd0, model(1'b1, 6'd17, 6'd0));
        #2;
        do_reset("mid_reset", 1);
        cycle("after_rst", 1'b1, 1'b1, 6'd45, 6'd7, '{1'b1, 6'd6, 6'd3, 1'b0});
        idle("after_rst_drain", W + 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
